// File: rtl/adler_pkg.sv
// Shared constants and types for the Adler-32 sink stage (frame geometry, data
// width, Adler modulus/initial value, FSM state, stage-1 register layout).
package adler_pkg;

    localparam int SIZE_W_WD   = 16;
    localparam int SIZE_H_WD   = 16;
    localparam int DATA_PXL_WD = 32;
    localparam int ADLER_WD    = 32;

    localparam logic [15:0]         ADLER_MOD  = 16'd65521;
    localparam logic [ADLER_WD-1:0] ADLER_INIT = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN,
        ST_FIN
    } adler_st_e;

    typedef struct packed {
        logic                   vld;
        logic [2:0]             n;
        logic [DATA_PXL_WD-1:0] word;
    } adler_stg_t;

    // Bytes a word may still contribute: min(4, remaining).
    function automatic logic [2:0] take_bytes(input logic [31:0] rem);
        return (rem >= 32'd4) ? 3'd4 : rem[2:0];
    endfunction

endpackage

// File: rtl/adler_upd.sv
// Combinational Adler-32 update for up to four MSB-first bytes, followed by
// the s1/s2 modular reductions. Inputs s1/s2 are assumed already < 65521.
module adler_upd
    import adler_pkg::*;
(
    input  logic [15:0]            s1_i,
    input  logic [15:0]            s2_i,
    input  logic [DATA_PXL_WD-1:0] word_i,
    input  logic [2:0]             n_i,
    output logic [15:0]            s1_o,
    output logic [15:0]            s2_o
);

    localparam logic [18:0] MOD19 = 19'(ADLER_MOD);

    logic [18:0] sum, wsum, x1, x2, r1, fold, r2;

    always_comb begin
        sum  = '0;
        wsum = '0;
        for (int k = 0; k < 4; k++) begin
            // Byte k carries weight n-k; bytes past n drop out entirely.
            if (3'(k) < n_i) begin
                sum  = sum + 19'(word_i[8*(3-k) +: 8]);
                wsum = wsum + 19'(n_i - 3'(k)) * 19'(word_i[8*(3-k) +: 8]);
            end
        end
        x1 = 19'(s1_i) + sum;
        x2 = 19'(s2_i) + 19'(n_i) * 19'(s1_i) + wsum;
        r1 = (x1 >= MOD19) ? x1 - MOD19 : x1;
        // 2^16 mod 65521 == 15, so the top bits fold back in with weight 15.
        fold = 19'(x2[18:16]) * 19'd15 + 19'(x2[15:0]);
        r2   = (fold >= MOD19) ? fold - MOD19 : fold;
        s1_o = r1[15:0];
        s2_o = r2[15:0];
    end

endmodule

// File: rtl/adler_top.sv
// Adler-32 over the filtered scanline byte stream, one 32-bit word per cycle.
// Optional overrun/restart error flag: define ADLER_OVR_CHK_EN.
module adler_top
    import adler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SIZE_W_WD-1:0]   cfg_w_i,
    input  logic [SIZE_H_WD-1:0]   cfg_h_i,
    input  logic                   start_i,
    input  logic                   val_i,
    input  logic [DATA_PXL_WD-1:0] dat_i,
`ifdef ADLER_OVR_CHK_EN
    output logic                   err_o,
`endif
    output logic                   done_o,
    output logic [ADLER_WD-1:0]    adler_o
);

    adler_st_e   state_q, state_d;
    adler_stg_t  stg_q, stg_d;
    logic [31:0] rem_q, total;
    logic [15:0] s1_q, s2_q, s1_upd, s2_upd;
    logic [2:0]  n_acc, n_upd;
    logic        acc, fin_ld, done_q;
    logic [ADLER_WD-1:0] adler_q;

    assign total = 32'(cfg_h_i) * (32'd1 + (32'(cfg_w_i) << 2));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = (total == 32'd0) ? ST_DRAIN : ST_ACC;
        end else begin
            case (state_q)
                ST_ACC:   if (val_i && rem_q <= 32'd4) state_d = ST_DRAIN;
                ST_DRAIN: state_d = ST_FIN;
                ST_FIN:   state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        acc    = (state_q == ST_ACC) && val_i && !start_i;
        n_acc  = take_bytes(rem_q);
        fin_ld = (state_q == ST_DRAIN) && !start_i;
    end

    assign stg_d = '{vld: acc, n: acc ? n_acc : 3'd0, word: dat_i};
    assign n_upd = stg_q.vld ? stg_q.n : 3'd0;

    adler_upd u_upd (
        .s1_i   (s1_q),
        .s2_i   (s2_q),
        .word_i (stg_q.word),
        .n_i    (n_upd),
        .s1_o   (s1_upd),
        .s2_o   (s2_upd)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg_q   <= '0;
            rem_q   <= '0;
            s1_q    <= 16'd1;
            s2_q    <= 16'd0;
            done_q  <= 1'b0;
            adler_q <= ADLER_INIT;
        end else begin
            stg_q  <= stg_d;
            done_q <= fin_ld;
            if (start_i) begin
                rem_q <= total;
                s1_q  <= 16'd1;
                s2_q  <= 16'd0;
            end else begin
                if (acc) rem_q <= rem_q - 32'(n_acc);
                s1_q <= s1_upd;
                s2_q <= s2_upd;
            end
            // Last word is still in stage 1 during DRAIN; capture it via the update path.
            if (fin_ld) adler_q <= {s2_upd, s1_upd};
        end
    end

    assign done_o  = done_q;
    assign adler_o = adler_q;

`ifdef ADLER_OVR_CHK_EN
    logic started_q, err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            started_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (start_i) begin
            started_q <= 1'b1;
            err_q     <= (state_q == ST_ACC);
        end else if (val_i && started_q && state_q != ST_ACC) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_adler_top.sv
// Directed bench for adler_top: byte-level Adler-32 reference model plus
// hand-computed checksums for the small frames.
module tb_adler_top;
    import adler_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] cfg_w = '0, cfg_h = '0;
    logic        start = 1'b0, val = 1'b0;
    logic [31:0] dat = '0;
    logic        done;
    logic [31:0] adler;
`ifdef ADLER_OVR_CHK_EN
    logic        err;
`endif

    adler_top dut (
        .clk     (clk),
        .rstn    (rstn),
        .cfg_w_i (cfg_w),
        .cfg_h_i (cfg_h),
        .start_i (start),
        .val_i   (val),
        .dat_i   (dat),
`ifdef ADLER_OVR_CHK_EN
        .err_o   (err),
`endif
        .done_o  (done),
        .adler_o (adler)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tot = 0, n_bad = 0;
    int          exp_done_cyc = -1;
    logic [31:0] exp_adler = 32'h1;
    logic        has_lit = 1'b0;
    logic [31:0] lit_adler = 32'h1;
    string       tag = "reset";
    logic [31:0] wq[$];

    always @(negedge clk) begin
        if (!rstn) begin
            n_tot++;
            if (done !== 1'b0 || adler !== 32'h0000_0001) begin
                n_bad++;
                $display("FAIL %s reset: done=%0b adler=%h, required done=0 adler=00000001", tag, done, adler);
            end
        end else begin
            n_tot++;
            if (done !== (cyc == exp_done_cyc)) begin
                n_bad++;
                $display("FAIL %s done cyc=%0d: got %0b required %0b", tag, cyc, done, cyc == exp_done_cyc);
            end
            if (exp_done_cyc >= 0 && cyc >= exp_done_cyc) begin
                n_tot++;
                if (adler !== exp_adler) begin
                    n_bad++;
                    $display("FAIL %s adler model cyc=%0d: got %h required %h", tag, cyc, adler, exp_adler);
                end
                if (has_lit && cyc == exp_done_cyc) begin
                    n_tot++;
                    if (adler !== lit_adler) begin
                        n_bad++;
                        $display("FAIL %s adler literal: got %h required %h", tag, adler, lit_adler);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame and stream ceil(total/4) words from wq; abort_after>0 stops early.
    task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input int gap_pct,
                             input int abort_after, input logic lit_en, input logic [31:0] lit,
                             input string name);
        int unsigned total;
        int          nw, cnt;
        int unsigned s1, s2;
        logic [31:0] wd;
        tick();
        start = 1'b1; cfg_w = w; cfg_h = h; val = 1'b1; dat = 32'hDEAD_BEEF;
        exp_done_cyc = -1; has_lit = 1'b0; tag = name;
        total = int'(h) * (1 + 4 * int'(w));
        nw = int'((total + 3) / 4);
        s1 = 1; s2 = 0; cnt = 0;
        for (int i = 0; i < nw; i++) begin
            wd = wq[i];
            for (int b = 0; b < 4; b++) begin
                if (cnt < int'(total)) begin
                    s1 = (s1 + wd[31-8*b -: 8]) % 65521;
                    s2 = (s2 + s1) % 65521;
                    cnt++;
                end
            end
        end
        if (nw == 0) begin
            exp_adler = {s2[15:0], s1[15:0]}; lit_adler = lit; has_lit = lit_en;
            exp_done_cyc = cyc + 2;
        end
        for (int i = 0; i < nw; i++) begin
            tick();
            start = 1'b0; val = 1'b0;
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) tick();
            if (abort_after > 0 && i == abort_after) return;
            val = 1'b1; dat = wq[i];
            if (i == nw - 1) begin
                exp_adler = {s2[15:0], s1[15:0]}; lit_adler = lit; has_lit = lit_en;
                exp_done_cyc = cyc + 2;
            end
        end
        tick();
        start = 1'b0; val = 1'b0;
        repeat (2) tick();
        // Words arriving after the frame must not disturb the held result.
        repeat (3) begin
            val = 1'b1; dat = $urandom;
            tick();
        end
        val = 1'b0;
        repeat (2) tick();
    endtask

    task automatic fill_const(input int n, input logic [31:0] v);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(v);
    endtask

    task automatic fill_rand(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        wq = '{32'h5769_6B69, 32'h7065_6469, 32'h6100_0000};
        run_frame(16'd2, 16'd1, 0, 0, 1'b1, 32'h11E6_0398, "wiki");

        fill_const(2, 32'h0);
        run_frame(16'd1, 16'd1, 0, 0, 1'b1, 32'h0005_0001, "zeros");

        fill_const(2, 32'hFFFF_FFFF);
        run_frame(16'd1, 16'd1, 0, 0, 1'b1, 32'h0EF6_04FC, "ones");

        wq.delete();
        run_frame(16'd5, 16'd0, 0, 0, 1'b1, 32'h0000_0001, "empty");

        fill_const(4112, 32'hFFFF_FFFF);
        run_frame(16'd64, 16'd64, 30, 0, 1'b0, 32'h0, "big_gapped");

        fill_rand(1028);
        run_frame(16'd64, 16'd16, 0, 0, 1'b0, 32'h0, "rand_contig");

        fill_rand(257);
        run_frame(16'd64, 16'd4, 0, 100, 1'b0, 32'h0, "aborted");
        wq = '{32'h5769_6B69, 32'h7065_6469, 32'h6100_0000};
        run_frame(16'd2, 16'd1, 0, 0, 1'b1, 32'h11E6_0398, "wiki_restart");

        fill_rand(17);
        run_frame(16'd8, 16'd2, 0, 5, 1'b0, 32'h0, "reset_abort");
        tag = "midreset";
        exp_done_cyc = -1;
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (4) tick();

        fill_const(2, 32'hFFFF_FFFF);
        run_frame(16'd1, 16'd1, 0, 0, 1'b1, 32'h0EF6_04FC, "ones_after_reset");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
